// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared encodings for the data-memory responder.
//   - SWHB access-size encodings (word / half / byte; 00 behaves as word)
//   - FSM state encoding for dmem_resp
//   - misaligned(): alignment rule used when DMEM_MISALIGN_CHECK_EN is defined
package dmem_resp_pkg;

   localparam logic [1:0] SWHB_WORD0 = 2'b00;
   localparam logic [1:0] SWHB_WORD  = 2'b01;
   localparam logic [1:0] SWHB_HALF  = 2'b10;
   localparam logic [1:0] SWHB_BYTE  = 2'b11;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

   function automatic logic misaligned(input logic [1:0] swhb, input logic [1:0] addr_lo);
      case (swhb)
         SWHB_HALF: return addr_lo[0];
         SWHB_BYTE: return 1'b0;
         default:   return (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/dmem_ldext.sv
// dmem_ldext: combinational load extraction / extension.
//   word_i      : full 32-bit RAM word
//   addr_lo_i   : byte offset addr[1:0]
//   swhb_i      : access size (01 word, 10 half, 11 byte, 00 word)
//   lunsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o      : write-back ready value
// A half access uses addr[1] only, so a misaligned half reads the aligned half.
module dmem_ldext
   import dmem_resp_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  swhb_i,
   input  logic        lunsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (addr_lo_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

      case (swhb_i)
         SWHB_HALF: data_o = {(lunsigned_i ? 16'h0000 : {16{half_sel[15]}}), half_sel};
         SWHB_BYTE: data_o = {(lunsigned_i ? 24'h000000 : {24{byte_sel[7]}}), byte_sel};
         default:   data_o = word_i;
      endcase
   end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder with an internal word-organised RAM.
// One access in flight; stores write at acceptance, loads are read and
// extended on the first RESP cycle and held until resp_ready.
// Ports:
//   clk, reset (sync, active-high)
//   req_valid/req_ready handshake, req_we, req_addr, req_swhb, req_amp,
//   req_wdata, req_lunsigned
//   resp_valid/resp_ready handshake, resp_rdata, resp_err
// Parameters: DEPTH_WORDS (power of two), WAIT_STATES (0..15)
// Build option: DMEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses
// with resp_err=1 and suppresses the write; otherwise resp_err is tied 0.
//
// state     | meaning
// DMEM_IDLE | ready for a request
// DMEM_WAIT | counting wait states after acceptance
// DMEM_RESP | first cycle: capture response; then hold until resp_ready
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_swhb,
   input  logic [3:0]  req_amp,
   input  logic [31:0] req_wdata,
   input  logic        req_lunsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [31:0] ram [DEPTH_WORDS];

   dmem_state_e state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          we_q, we_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    lo_q, lo_d;
   logic [1:0]    swhb_q, swhb_d;
   logic          lu_q, lu_d;
   logic          err_q, err_d;

   logic          accept;
   logic          req_bad;
   logic          wr_en;
   logic [31:0]   ram_word;
   logic [31:0]   ld_data;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:AW+2];

   assign req_ready = (state_q == DMEM_IDLE) && !reset;
   assign accept    = req_valid && req_ready;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign req_bad  = misaligned(req_swhb, req_addr[1:0]);
   assign resp_err = err_q;
`else
   assign req_bad  = 1'b0;
   assign resp_err = 1'b0;
`endif

   assign wr_en      = accept && req_we && !req_bad;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;

   // Write and read never share a cycle: writes happen in IDLE, reads in RESP.
   assign ram_word = ram[idx_q];

   dmem_ldext u_ldext (
      .word_i      (ram_word),
      .addr_lo_i   (lo_q),
      .swhb_i      (swhb_q),
      .lunsigned_i (lu_q),
      .data_o      (ld_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      swhb_d  = swhb_q;
      lu_d    = lu_q;
      err_d   = err_q;
      case (state_q)
         DMEM_IDLE: begin
            if (accept) begin
               we_d   = req_we;
               idx_d  = req_addr[AW+1:2];
               lo_d   = req_addr[1:0];
               swhb_d = req_swhb;
               lu_d   = req_lunsigned;
               err_d  = req_bad;
               if (WAIT_STATES > 0) begin
                  state_d = DMEM_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = DMEM_RESP;
               end
            end
         end
         DMEM_WAIT: begin
            if (cnt_q == 4'd0) state_d = DMEM_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DMEM_RESP: begin
            if (!valid_q) begin
               valid_d = 1'b1;
               rdata_d = (we_q || err_q) ? 32'h0 : ld_data;
            end else if (resp_ready) begin
               valid_d = 1'b0;
               state_d = DMEM_IDLE;
            end
         end
         default: state_d = DMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Request fields need no reset: they are only consumed after an acceptance.
   always_ff @(posedge clk) begin
      we_q   <= we_d;
      idx_q  <= idx_d;
      lo_q   <= lo_d;
      swhb_q <= swhb_d;
      lu_q   <= lu_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (req_amp[i]) ram[req_addr[AW+1:2]][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

endmodule
